// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port. It accepts one byte, half or word request at a
// time over valid/ready and waits LATENCY cycles. It then commits the access to a little-endian
// byte RAM and holds the response until the consumer takes it.
module data_mem_responder #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [2:0]       req_mode,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int unsigned MemBytes = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  CntLoad  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  logic [7:0] mem [MemBytes];

  logic [ADDR_WIDTH-1:0] idx0, idx1, idx2, idx3;
  logic [7:0]            b0, b1, b2, b3;
  logic                  access_err;
  logic [WIDTH-1:0]      load_data;
  logic                  commit;
  logic                  mem_wr;

  // Halves and words are naturally aligned when legal, so the lane indices never wrap.
  assign idx0 = addr_q[ADDR_WIDTH-1:0];
  assign idx1 = idx0 + ADDR_WIDTH'(1);
  assign idx2 = idx0 + ADDR_WIDTH'(2);
  assign idx3 = idx0 + ADDR_WIDTH'(3);
  assign b0   = mem[idx0];
  assign b1   = mem[idx1];
  assign b2   = mem[idx2];
  assign b3   = mem[idx3];

  assign commit    = (state_q == StBusy) && (cnt_q == 4'd0);
  assign mem_wr    = commit && we_q && !access_err;
  assign req_ready = (state_q == StIdle) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Decide whether the latched request is legal: alignment, mode encoding and range.
  always_comb begin
    access_err = 1'b0;
    case (mode_q)
      3'b000:  access_err = 1'b0;
      3'b001:  access_err = addr_q[0];
      3'b010:  access_err = (addr_q[1:0] != 2'b00);
      3'b100:  access_err = we_q;
      3'b101:  access_err = we_q | addr_q[0];
      default: access_err = 1'b1;
    endcase
    if (addr_q[WIDTH-1:ADDR_WIDTH] != '0) begin
      access_err = 1'b1;
    end
  end

  // Assemble and extend the load result from the addressed bytes.
  always_comb begin
    load_data = '0;
    case (mode_q)
      3'b000:  load_data = {{(WIDTH-8){b0[7]}}, b0};
      3'b001:  load_data = {{(WIDTH-16){b1[7]}}, b1, b0};
      3'b010:  load_data = WIDTH'({b3, b2, b1, b0});
      3'b100:  load_data = WIDTH'(b0);
      3'b101:  load_data = WIDTH'({b1, b0});
      default: load_data = '0;
    endcase
  end

  // Next-state logic: accept in idle, count down in busy, hold the response until taken.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    mode_d      = mode_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          mode_d  = req_mode;
          wdata_d = req_wdata;
          cnt_d   = CntLoad;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = access_err;
          rsp_rdata_d = (we_q || access_err) ? '0 : load_data;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      mode_q      <= 3'b000;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      mode_q      <= mode_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Store commit on the busy->resp edge; a reset on that edge aborts the write.
  always_ff @(posedge clk) begin
    if (!rst && mem_wr) begin
      case (mode_q)
        3'b000: mem[idx0] <= wdata_q[7:0];
        3'b001: begin
          mem[idx0] <= wdata_q[7:0];
          mem[idx1] <= wdata_q[15:8];
        end
        3'b010: begin
          mem[idx0] <= wdata_q[7:0];
          mem[idx1] <= wdata_q[15:8];
          mem[idx2] <= wdata_q[23:16];
          mem[idx3] <= wdata_q[31:24];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_mode;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int nvec  = 0;
  int nfail = 0;

  localparam logic [2:0] MB = 3'b000, MH = 3'b001, MW = 3'b010, MBU = 3'b100, MHU = 3'b101;

  data_mem_responder #(.WIDTH(32), .ADDR_WIDTH(12), .LATENCY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_mode  (req_mode),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  mode;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %08h, want %08h", name, act, exp);
    end
  endtask

  // Issue one request, scramble inputs after acceptance, wait for the response and check it.
  task automatic run_req(input string name, input logic we, input logic [31:0] addr,
                         input logic [2:0] mode, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_mode  = mode;
    req_wdata = wdata;
    check({name, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = ~addr;
    req_mode  = ~mode;
    req_wdata = ~wdata;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      #1;
      if (rsp_valid) break;
    end
    check({name, ".latency"}, 32'(n), 32'd2);
    check({name, ".rdata"}, rsp_rdata, exp_rdata);
    check({name, ".err"}, 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check({name, ".rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
    check({name, ".idle_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    vecs.push_back('{"sw_100", 1, 32'h100, MW, 32'hDEADBEEF, 32'h0, 0});
    vecs.push_back('{"lw_100", 0, 32'h100, MW, 32'h0, 32'hDEADBEEF, 0});
    vecs.push_back('{"lb_101", 0, 32'h101, MB, 32'h0, 32'hFFFFFFBE, 0});
    vecs.push_back('{"lbu_101", 0, 32'h101, MBU, 32'h0, 32'h000000BE, 0});
    vecs.push_back('{"lh_102", 0, 32'h102, MH, 32'h0, 32'hFFFFDEAD, 0});
    vecs.push_back('{"lhu_102", 0, 32'h102, MHU, 32'h0, 32'h0000DEAD, 0});
    vecs.push_back('{"sb_103", 1, 32'h103, MB, 32'h12345655, 32'h0, 0});
    vecs.push_back('{"lw_after_sb", 0, 32'h100, MW, 32'h0, 32'h55ADBEEF, 0});
    vecs.push_back('{"lb_103_pos", 0, 32'h103, MB, 32'h0, 32'h00000055, 0});
    vecs.push_back('{"sh_100", 1, 32'h100, MH, 32'h0000A5A5, 32'h0, 0});
    vecs.push_back('{"lw_after_sh", 0, 32'h100, MW, 32'h0, 32'h55ADA5A5, 0});
    vecs.push_back('{"lb_100", 0, 32'h100, MB, 32'h0, 32'hFFFFFFA5, 0});
    vecs.push_back('{"lh_100", 0, 32'h100, MH, 32'h0, 32'hFFFFA5A5, 0});
    vecs.push_back('{"lw_mis", 0, 32'h102, MW, 32'h0, 32'h0, 1});
    vecs.push_back('{"sw_oor", 1, 32'h1000, MW, 32'h0, 32'h0, 1});
    vecs.push_back('{"sbu_illegal", 1, 32'h100, MBU, 32'hFFFFFFFF, 32'h0, 1});
    vecs.push_back('{"shu_illegal", 1, 32'h100, MHU, 32'hFFFFFFFF, 32'h0, 1});
    vecs.push_back('{"sh_mis", 1, 32'h101, MH, 32'hFFFFFFFF, 32'h0, 1});
    vecs.push_back('{"sw_mis", 1, 32'h101, MW, 32'hFFFFFFFF, 32'h0, 1});
    vecs.push_back('{"mode_011", 1, 32'h100, 3'b011, 32'hFFFFFFFF, 32'h0, 1});
    vecs.push_back('{"mode_111", 0, 32'h100, 3'b111, 32'h0, 32'h0, 1});
    vecs.push_back('{"lw_unchanged", 0, 32'h100, MW, 32'h0, 32'h55ADA5A5, 0});

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_mode = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.req_ready", 32'(req_ready), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.release_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) begin
      run_req(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].mode, vecs[i].wdata,
              vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Response held for 5 cycles while stray requests are offered.
    begin
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_mode = MW;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      n = 0;
      while (n < 20) begin
        @(posedge clk);
        n++;
        #1;
        if (rsp_valid) break;
      end
      check("hold.latency", 32'(n), 32'd2);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        req_valid = c[0];
        req_we    = 1'b1;
        req_addr  = 32'h100;
        req_mode  = MW;
        req_wdata = 32'h0;
        @(posedge clk);
        #1;
        check("hold.rsp_valid", 32'(rsp_valid), 32'd1);
        check("hold.rdata", rsp_rdata, 32'h55ADA5A5);
        check("hold.err", 32'(rsp_err), 32'd0);
        check("hold.req_ready", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("hold.release", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      rsp_ready = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("hold.no_stray_rsp", 32'(rsp_valid), 32'd0);
    end
    run_req("hold.mem_intact", 0, 32'h100, MW, 32'h0, 32'h55ADA5A5, 0);

    // Reset while busy aborts the pending store.
    run_req("sw_200", 1, 32'h200, MW, 32'h11111111, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h200; req_mode = MW; req_wdata = 32'h22222222;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("busy_rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("busy_rst.req_ready", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("busy_rst.quiet", 32'(rsp_valid), 32'd0);
    run_req("busy_rst.lw_200", 0, 32'h200, MW, 32'h0, 32'h11111111, 0);

    // Reset while a response is pending drops it.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h200; req_mode = MW;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("resp_rst.pending", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("resp_rst.dropped", 32'(rsp_valid), 32'd0);
    check("resp_rst.rdata", rsp_rdata, 32'd0);
    check("resp_rst.req_ready", 32'(req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
